// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, three majority-voted samples per bit, valid/ready output.
// Optional even-parity bit (8E1) when the macro UART_RX_PARITY_EN is defined; default is 8N1.
module uart_rx #(
  parameter int CLK_FREQ = 200_000_000,
  parameter int BAUDRATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       rx_busy
);

  localparam int CNT_3T = CLK_FREQ / (BAUDRATE * 3);
  localparam int CNT_6T = CLK_FREQ / (BAUDRATE * 6);
  localparam logic [17:0] CNT_3T_LAST = 18'(CNT_3T - 1);
  localparam logic [17:0] CNT_6T_LAST = 18'(CNT_6T - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic        r_rx_meta;
  logic        r_rx_s;

  state_t      r_state,  w_state_nxt;
  logic [17:0] r_cnt,    w_cnt_nxt;
  logic [1:0]  r_sidx,   w_sidx_nxt;
  logic [1:0]  r_samp,   w_samp_nxt;
  logic [2:0]  r_bidx,   w_bidx_nxt;
  logic [7:0]  r_shift,  w_shift_nxt;
  logic [7:0]  r_data,   w_data_nxt;
  logic        r_valid,  w_valid_nxt;
  logic        r_ferr,   w_ferr_nxt;
  logic        r_ovr,    w_ovr_nxt;
`ifdef UART_RX_PARITY_EN
  logic        r_par,    w_par_nxt;
  logic        r_perr,   w_perr_nxt;
`endif

  logic        w_tick;
  logic        w_bit_done;
  logic        w_vote;
  logic        w_sampling;

  // Both flops reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns these two lines into a two-stage shift rather than a wire.
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick     = (r_cnt == CNT_3T_LAST);
  assign w_bit_done = w_tick && (r_sidx == 2'd2);
  // Third sample is the live synchronised value; the first two are stored.
  assign w_vote     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s) | (r_samp[1] & r_rx_s);
  assign w_sampling = (r_state != S_IDLE) && (r_state != S_ALIGN) && (r_state != S_BREAK);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves one
    // unassigned and no latch can be inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 18'd1;
    w_sidx_nxt  = r_sidx;
    w_samp_nxt  = r_samp;
    w_bidx_nxt  = r_bidx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid && !rx_ready;
    w_ferr_nxt  = 1'b0;
    w_ovr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_perr_nxt  = 1'b0;
`endif

    if (w_sampling && w_tick) begin
      w_cnt_nxt = '0;
      if (r_sidx == 2'd2) begin
        w_sidx_nxt = 2'd0;
      end else begin
        w_samp_nxt[r_sidx[0]] = r_rx_s;
        w_sidx_nxt            = r_sidx + 2'd1;
      end
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) w_state_nxt = S_ALIGN;
      end

      S_ALIGN: begin
        if (r_cnt == CNT_6T_LAST) begin
          w_cnt_nxt     = '0;
          w_samp_nxt[0] = r_rx_s;
          w_sidx_nxt    = 2'd1;
          w_state_nxt   = S_START;
        end
      end

      S_START: begin
        if (w_bit_done) begin
          if (w_vote) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_bidx_nxt  = 3'd0;
            w_state_nxt = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (w_bit_done) begin
          w_shift_nxt = {w_vote, r_shift[7:1]};
          w_bidx_nxt  = r_bidx + 3'd1;
          if (r_bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_bit_done) begin
          w_par_nxt   = w_vote;
          w_state_nxt = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (w_bit_done) begin
          if (w_vote) begin
            // A byte can land in the same cycle the consumer takes the previous one.
            if (!r_valid || rx_ready) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_ovr_nxt = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            w_perr_nxt = (r_par != ^r_shift);
`endif
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        w_cnt_nxt = '0;
        if (r_rx_s) w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sidx  <= 2'd0;
      r_samp  <= 2'b00;
      r_bidx  <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sidx  <= w_sidx_nxt;
      r_samp  <= w_samp_nxt;
      r_bidx  <= w_bidx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_ovr   <= w_ovr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_ferr;
  assign rx_overrun   = r_ovr;
  assign rx_busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: builds a per-clock line waveform, predicts every output cycle from
// the frame timing rules, then replays the waveform and compares each cycle.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_200_000;
  localparam int BAUDRATE = 100_000;
  localparam int CNT3     = CLK_FREQ / (BAUDRATE * 3);
  localparam int CNT6     = CLK_FREQ / (BAUDRATE * 6);
  localparam int BITLEN   = 3 * CNT3;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;
  logic       obs_perr;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUDRATE(BAUDRATE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(obs_perr),
`endif
    .rx_busy      (rx_busy)
  );

`ifndef UART_RX_PARITY_EN
  assign obs_perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus: one entry per clock cycle.
  bit wq[$];
  bit rq[$];
  bit dq[$];

  int N;
  bit wv[];
  bit rstv[];
  bit rdv[];

  bit          busy_e[];
  bit          ferr_e[];
  bit          ovr_e[];
  bit          perr_e[];
  bit          ev_stop[];
  bit          ev_perr[];
  logic [7:0]  ev_byte[];
  logic [12:0] expv[];

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // rdy: 0/1 fixed, 2 = random each cycle.
  task automatic put(input bit lvl, input int n, input int rdy, input bit r = 1'b0);
    repeat (n) begin
      wq.push_back(lvl);
      rq.push_back(r);
      dq.push_back((rdy == 2) ? bit'($urandom_range(0, 1)) : bit'(rdy));
    end
  endtask

  // stop_lo > 0 holds the stop bit low for that many clocks.
  task automatic frame(input logic [7:0] b, input int rdy, input bit pflip, input int stop_lo);
    put(1'b0, BITLEN, rdy);
    for (int i = 0; i < 8; i++) put(b[i], BITLEN, rdy);
    if (NPAR != 0) put((^b) ^ pflip, BITLEN, rdy);
    if (stop_lo > 0) put(1'b0, stop_lo, rdy);
    else             put(1'b1, BITLEN, rdy);
  endtask

  // Synchronised line as seen by the receiver in cycle c.
  function automatic bit rxs(input int c);
    if (c < 2 || c > N) return 1'b1;
    if (rstv[c-1] || rstv[c-2]) return 1'b1;
    return wv[c-2];
  endfunction

  function automatic bit vote3(input int t0, input int n);
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) s += int'(rxs(t0 + CNT6 + (3 * n + k) * CNT3));
    return (s >= 2);
  endfunction

  function automatic int first_rst(input int a, input int b);
    for (int i = a; i <= b && i < N; i++) if (rstv[i]) return i;
    return -1;
  endfunction

  task automatic mark_busy(input int a, input int b);
    for (int i = a; i <= b && i < N + 2; i++) busy_e[i] = 1'b1;
  endtask

  task automatic build_model();
    int t, t0, td, r, c;
    logic [7:0] b, d;
    bit v, rej;
    busy_e  = new[N + 2];
    ferr_e  = new[N + 2];
    ovr_e   = new[N + 2];
    perr_e  = new[N + 2];
    ev_stop = new[N + 2];
    ev_perr = new[N + 2];
    ev_byte = new[N + 2];
    expv    = new[N];
    t = 0;
    while (t < N) begin
      if (rstv[t] || rxs(t)) begin
        t++;
        continue;
      end
      t0  = t;
      rej = vote3(t0, 0);
      td  = rej ? t0 + CNT6 + 2 * CNT3 : t0 + CNT6 + (3 * (9 + NPAR) + 2) * CNT3;
      if (td >= N) break;
      r = first_rst(t0, td);
      if (r >= 0) begin
        mark_busy(t0 + 1, r);
        t = r + 1;
        continue;
      end
      mark_busy(t0 + 1, td);
      if (rej) begin
        t = td + 1;
        continue;
      end
      for (int i = 0; i < 8; i++) b[i] = vote3(t0, i + 1);
      if (vote3(t0, 9 + NPAR)) begin
        ev_stop[td] = 1'b1;
        ev_byte[td] = b;
        ev_perr[td] = (NPAR != 0) && (vote3(t0, 9) != ^b);
        t = td + 1;
      end else begin
        ferr_e[td + 1] = 1'b1;
        c = td + 1;
        while (c < N && !rstv[c] && !rxs(c)) c++;
        mark_busy(td + 1, c);
        t = c + 1;
      end
    end
    v = 1'b0;
    d = 8'h00;
    for (int k = 0; k < N; k++) begin
      expv[k] = {busy_e[k], v, ferr_e[k], ovr_e[k], perr_e[k], d};
      if (rstv[k]) begin
        v = 1'b0;
        d = 8'h00;
      end else if (ev_stop[k]) begin
        if (!v || rdv[k]) begin
          v = 1'b1;
          d = ev_byte[k];
        end else begin
          ovr_e[k + 1] = 1'b1;
        end
        perr_e[k + 1] = ev_perr[k];
      end else if (rdv[k]) begin
        v = 1'b0;
      end
    end
  endtask

  initial begin
    int base;
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;

    // Step 1: reset, then idle.
    put(1'b1, 4, 1, 1'b1);
    put(1'b1, 16, 1);

    // Step 2: basic receive of 0xA5 with the consumer always ready.
    frame(8'hA5, 1, 1'b0, 0);
    put(1'b1, 20, 1);

    // Step 3: overrun: two back-to-back bytes with nobody consuming, then drain.
    frame(8'h3C, 0, 1'b0, 0);
    frame(8'h81, 0, 1'b0, 0);
    put(1'b1, 10, 0);
    put(1'b1, 10, 1);

    // Step 4: short low glitch is rejected by the start vote.
    put(1'b0, 4, 1);
    put(1'b1, 30, 1);

    // Step 5: framing error with stop held low, then a clean 0x12.
    frame(8'h55, 1, 1'b0, 24);
    put(1'b1, 20, 1);
    frame(8'h12, 1, 1'b0, 0);
    put(1'b1, 20, 1);

    // Step 6: 0xFF with a 4-clock dip over the middle sample of data bit 3.
    base = wq.size();
    frame(8'hFF, 1, 1'b0, 0);
    for (int j = 0; j < 4; j++) wq[base + 4 * BITLEN + 4 + j] = 1'b0;
    put(1'b1, 20, 1);

    // Step 7: reset in the middle of data bit 4, then 0x07 with a wrong parity bit.
    put(1'b0, BITLEN, 1);
    put(1'b1, BITLEN, 1);
    put(1'b1, BITLEN, 1);
    put(1'b0, BITLEN, 1);
    put(1'b0, BITLEN, 1);
    put(1'b0, 6, 1);
    put(1'b1, 3, 1, 1'b1);
    put(1'b1, 30, 1);
    frame(8'h07, 1, 1'b1, 0);
    put(1'b1, 20, 1);

    // Step 8: random bytes, gaps, ready pattern, parity flips and occasional bad stops.
    repeat (24) begin
      frame(8'($urandom), 2, bit'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 20)) : 0);
      put(1'b1, $urandom_range(0, 15), 2);
    end
    put(1'b1, 40, 1);

    N    = wq.size();
    wv   = new[N];
    rstv = new[N];
    rdv  = new[N];
    for (int i = 0; i < N; i++) begin
      wv[i]   = wq[i];
      rstv[i] = rq[i];
      rdv[i]  = dq[i];
    end
    build_model();

    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      rx       = wv[c];
      rst      = rstv[c];
      rx_ready = rdv[c];
      @(negedge clk);
      if (c >= 1)
        check($sformatf("cycle %0d {busy,valid,ferr,ovr,perr,data}", c),
              {rx_busy, rx_valid, rx_frame_err, rx_overrun, obs_perr, rx_data}, expv[c]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
